// File: rtl/axis_rr_arb_if.sv
// Stream bundle between N_PORTS upstream producers, the round-robin arbiter
// and the single downstream consumer.
// master: the upstream producers plus the downstream sink.
// slave:  the arbiter.
interface axis_rr_arb_if #(
    parameter int N_PORTS = 4,
    parameter int D_WIDTH = 6
);
    localparam int S_W = $clog2(N_PORTS);

    logic [N_PORTS*D_WIDTH-1:0] s_data;
    logic [N_PORTS-1:0]         s_valid;
    logic [N_PORTS-1:0]         s_last;
    logic [N_PORTS-1:0]         s_ready;
    logic [D_WIDTH-1:0]         m_data;
    logic                       m_valid;
    logic                       m_last;
    logic                       m_ready;
    logic [S_W-1:0]             m_src;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_src
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, m_src
    );
endinterface

// File: rtl/axis_rr_arb.sv
// Round-robin AXI-Stream arbiter: N_PORTS upstream streams share one
// downstream port. A grant is registered in IDLE and the granted stream is
// passed through combinationally while LOCKED. Releasing always costs one
// IDLE bubble cycle.
// Optional feature: define AXIS_ARB_PKT_LOCK_EN to hold the grant until the
// last beat of a packet; without it the grant is released after every
// accepted beat.
module axis_rr_arb #(
    parameter int N_PORTS = 4,
    parameter int D_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    axis_rr_arb_if.slave   bus
);
    localparam int S_W = $clog2(N_PORTS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [S_W-1:0] grant_q, grant_d;
    logic [S_W-1:0] prio_q,  prio_d;

    logic [S_W-1:0] pick;
    logic           found;
    int             idx;
    logic           accept;
    logic           release_grant;

    // Round-robin scan starting at prio: first requesting port wins.
    always_comb begin
        pick  = prio_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(prio_q) + k;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!found && bus.s_valid[idx[S_W-1:0]]) begin
                pick  = idx[S_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Control registers; the datapath itself is an unregistered mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state logic and handshake outputs; ready never depends on valid.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        prio_d        = prio_q;
        bus.m_valid   = 1'b0;
        bus.s_ready   = '0;
        accept        = 1'b0;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                bus.m_valid          = bus.s_valid[grant_q];
                bus.s_ready[grant_q] = bus.m_ready;
                accept               = bus.s_valid[grant_q] & bus.m_ready;
`ifdef AXIS_ARB_PKT_LOCK_EN
                release_grant        = accept & bus.s_last[grant_q];
`else
                release_grant        = accept;
`endif
                if (release_grant) begin
                    state_d = IDLE;
                    // Wrap at N_PORTS, which need not be a power of two.
                    if (grant_q == S_W'(N_PORTS - 1)) begin
                        prio_d = '0;
                    end else begin
                        prio_d = grant_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data mux from the granted port; follows grant even while IDLE.
    always_comb begin
        bus.m_data = bus.s_data[D_WIDTH-1:0];
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == S_W'(i)) begin
                bus.m_data = bus.s_data[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    assign bus.m_last = bus.s_last[grant_q];
    assign bus.m_src  = grant_q;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Testbench for axis_rr_arb: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level arbiter model.
// Works with or without AXIS_ARB_PKT_LOCK_EN defined.
module tb_axis_rr_arb;
    localparam int N  = 4;
    localparam int W  = 6;
    localparam int SW = $clog2(N);
`ifdef AXIS_ARB_PKT_LOCK_EN
    localparam bit PKT_LOCK = 1'b1;
    int exp_src2[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_gap2[9]  = '{1, 2, 1, 2, 1, 2, 1, 2, 1};
    int exp_span3    = 10;
    int exp_src4[4]  = '{1, 1, 1, 0};
`else
    localparam bit PKT_LOCK = 1'b0;
    int exp_src2[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    int exp_gap2[9]  = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    int exp_span3    = 16;
    int exp_src4[4]  = '{1, 0, 1, 1};
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_rr_arb_if #(.N_PORTS(N), .D_WIDTH(W)) bus ();
    axis_rr_arb #(.N_PORTS(N), .D_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: whether some port owns the output, which one, and the
    // port that has first claim at the next arbitration.
    bit            mdl_locked = 1'b0;
    logic [SW-1:0] mdl_owner  = '0;
    int            mdl_prio   = 0;
    int            cyc        = 0;
    int            beat_src[$];
    int            beat_cyc[$];

    // Upstream producer state.
    int            pkts_left[N];
    int            beats_left[N];
    int            plen[N];
    logic [W-1:0]  cur_data[N];
    bit            acc_seen[N];
    int            sent_cnt = 0;
    int            vprob = 100;
    int            rprob = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Winner = requesting port at the smallest rotational distance from prio.
    function automatic int pick_port(input logic [N-1:0] v, input int prio);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - prio + N) % N;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_data;
        cyc++;
        for (int i = 0; i < N; i++) acc_seen[i] = bus.s_valid[i] & bus.s_ready[i];
        if (bus.m_valid && bus.m_ready) begin
            beat_src.push_back(int'(bus.m_src));
            beat_cyc.push_back(cyc);
        end
        if (!rst) begin
            exp_ready = mdl_locked ? (N'(bus.m_ready) << mdl_owner) : '0;
            check("m_valid", 32'(bus.m_valid), 32'(mdl_locked && bus.s_valid[mdl_owner]));
            check("s_ready", 32'(bus.s_ready), 32'(exp_ready));
            if (mdl_locked) begin
                check("m_src", 32'(bus.m_src), 32'(mdl_owner));
            end
            if (mdl_locked && bus.s_valid[mdl_owner]) begin
                exp_data = W'(bus.s_data >> (int'(mdl_owner) * W));
                check("m_data", 32'(bus.m_data), 32'(exp_data));
                check("m_last", 32'(bus.m_last), 32'(bus.s_last[mdl_owner]));
            end
        end
        if (rst) begin
            mdl_locked = 1'b0;
            mdl_owner  = '0;
            mdl_prio   = 0;
        end else if (!mdl_locked) begin
            if (|bus.s_valid) begin
                mdl_owner  = SW'(pick_port(bus.s_valid, mdl_prio));
                mdl_locked = 1'b1;
            end
        end else if (bus.s_valid[mdl_owner] && bus.m_ready) begin
            if (!PKT_LOCK || bus.s_last[mdl_owner]) begin
                mdl_locked = 1'b0;
                mdl_prio   = (int'(mdl_owner) + 1) % N;
            end
        end
    end

    task automatic start_pkt(input int i);
        beats_left[i] = (plen[i] > 0) ? plen[i] : int'($urandom_range(4, 1));
        cur_data[i]   = W'($urandom);
    endtask

    task automatic load(input int i, input int npk, input int len);
        plen[i]      = len;
        pkts_left[i] = npk;
        if (npk > 0) start_pkt(i);
    endtask

    // One clock: retire accepted beats, then drive the next input values.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i]) begin
                sent_cnt++;
                beats_left[i]--;
                if (beats_left[i] == 0) begin
                    pkts_left[i]--;
                    if (pkts_left[i] > 0) start_pkt(i);
                end else begin
                    cur_data[i] = W'($urandom);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            bus.s_valid[i]        = (pkts_left[i] > 0) && (int'($urandom_range(99, 0)) < vprob);
            bus.s_last[i]         = (beats_left[i] == 1);
            bus.s_data[i*W +: W]  = cur_data[i];
        end
        bus.m_ready = int'($urandom_range(99, 0)) < rprob;
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int k = 0;
        while (beat_src.size() < target && k < budget) begin
            step();
            k++;
        end
        if (beat_src.size() < target) check(name, 32'(beat_src.size()), 32'(target));
    endtask

    initial begin
        int base;
        int k;
        bit busy;
        int sent0;
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 0; beats_left[i] = 0; plen[i] = 1; cur_data[i] = '0; acc_seen[i] = 1'b0;
        end
        bus.s_valid = '0;
        bus.s_last  = '0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        // Reset, then ten idle cycles.
        repeat (3) step();
        rst = 1'b0;
        repeat (10) begin
            step();
            @(negedge clk);
            check("idle_m_valid", 32'(bus.m_valid), 32'd0);
            check("idle_s_ready", 32'(bus.s_ready), 32'd0);
            check("idle_m_src",   32'(bus.m_src),   32'd0);
        end

        // All four ports, 2-beat packets, downstream always ready.
        base = beat_src.size();
        for (int i = 0; i < N; i++) load(i, 3, 2);
        wait_beats(base + 24, 300, "all_ports_timeout");
        for (int j = 0; j < 10; j++) check("all_ports_src", 32'(beat_src[base + j]), 32'(exp_src2[j]));
        for (int j = 0; j < 9; j++)
            check("all_ports_gap", 32'(beat_cyc[base + j + 1] - beat_cyc[base + j]), 32'(exp_gap2[j]));
        repeat (3) step();

        // Port 2 alone, three 3-beat packets.
        base = beat_src.size();
        load(2, 3, 3);
        wait_beats(base + 9, 200, "port2_timeout");
        for (int j = 0; j < 9; j++) check("port2_src", 32'(beat_src[base + j]), 32'd2);
        check("port2_span", 32'(beat_cyc[base + 8] - beat_cyc[base]), 32'(exp_span3));
        repeat (3) step();

        // prio is now 3: ports 0 and 3 together, port 3 first, then wrap to 0.
        base = beat_src.size();
        load(0, 1, 1);
        load(3, 1, 1);
        wait_beats(base + 2, 100, "wrap_timeout");
        check("wrap_first",  32'(beat_src[base]),     32'd3);
        check("wrap_second", 32'(beat_src[base + 1]), 32'd0);
        check("wrap_gap", 32'(beat_cyc[base + 1] - beat_cyc[base]), 32'd2);
        repeat (3) step();

        // Port 1 stalled by downstream backpressure while port 0 waits.
        base = beat_src.size();
        load(1, 1, 3);
        load(0, 1, 1);
        wait_beats(base + 1, 100, "stall_start_timeout");
        rprob = 0;
        bus.m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_s_ready", 32'(bus.s_ready), 32'd0);
            step();
        end
        rprob = 100;
        wait_beats(base + 4, 100, "stall_end_timeout");
        for (int j = 0; j < 4; j++) check("stall_src", 32'(beat_src[base + j]), 32'(exp_src4[j]));
        repeat (3) step();

        // Reset in the middle of a 4-beat packet from port 2.
        base = beat_src.size();
        load(2, 1, 4);
        wait_beats(base + 2, 100, "rst_pkt_timeout");
        rst = 1'b1;
        bus.m_ready = 1'b0;
        bus.s_valid = '0;
        pkts_left[2] = 0;
        rprob = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("post_rst_m_src",   32'(bus.m_src),   32'd0);
        base = beat_src.size();
        rprob = 100;
        load(1, 1, 1);
        load(2, 1, 1);
        wait_beats(base + 2, 100, "post_rst_timeout");
        check("post_rst_first",  32'(beat_src[base]),     32'd1);
        check("post_rst_second", 32'(beat_src[base + 1]), 32'd2);
        repeat (3) step();

        // Randomized traffic: random lengths, valid gaps and backpressure.
        base  = beat_src.size();
        sent0 = sent_cnt;
        vprob = 70;
        rprob = 60;
        for (int i = 0; i < N; i++) load(i, 30, 0);
        k = 0;
        busy = 1'b1;
        while (busy && k < 20000) begin
            step();
            k++;
            busy = 1'b0;
            for (int i = 0; i < N; i++) if (pkts_left[i] > 0) busy = 1'b1;
        end
        if (busy) check("random_timeout", 32'(k), 32'd20000);
        repeat (3) step();
        check("random_beat_count", 32'(beat_src.size() - base), 32'(sent_cnt - sent0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axis_rr_arb.md
# axis_rr_arb

Round-robin, packet-aware AXI-Stream arbiter that lets N_PORTS upstream producers share one flop-based stream FIFO. Each upstream port presents data/valid/last. The arbiter registers a grant and passes the granted port's stream through to the single downstream port, which normally drives the FIFO's upstream interface. When packet lock is compiled in, a grant is held until the end of the packet.

## Interface
- N_PORTS, 4: number of upstream requesters; legal range 2..16.
- D_WIDTH, 6: data width per port; equals the data width of the downstream FIFO.
- S_W, $clog2(N_PORTS): derived localparam; width of the grant index.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- s_data  in  N_PORTS*D_WIDTH  upstream data; port i occupies bits [i*D_WIDTH +: D_WIDTH].
- s_valid  in  N_PORTS  upstream valid, one bit per port.
- s_last  in  N_PORTS  upstream end-of-packet, one bit per port.
- s_ready  out  N_PORTS  upstream ready; at most one bit is high at a time.
- m_data  out  D_WIDTH  downstream data, i.e. s_data of the granted port.
- m_valid  out  1  downstream valid.
- m_last  out  1  downstream end-of-packet, i.e. s_last of the granted port.
- m_ready  in  1  downstream ready; connects to the FIFO's ready (not full).
- m_src  out  S_W  index of the currently granted port.

## Operation
- Registers:
  - state: IDLE or LOCKED.
  - grant: S_W bits.
  - prio: S_W bits; the highest-priority port for the next arbitration.
- IDLE:
  - m_valid=0 and s_ready=0.
  - If any s_valid bit is set, grant gets the first port i with s_valid[i]=1, scanning i = prio, prio+1, … modulo N_PORTS. State then goes to LOCKED.
  - If no s_valid bit is set, stay in IDLE with no register change.
- LOCKED:
  - m_valid = s_valid[grant].
  - s_ready[grant] = m_ready; every other s_ready bit is 0.
  - m_data and m_last are muxed from the granted port.
  - A beat is accepted when m_valid & m_ready.
- Release condition: an accepted beat with s_last[grant]=1 (with the macro), or any accepted beat (without the macro). On release: state←IDLE and prio←(grant+1) mod N_PORTS. The mod wraps at N_PORTS, not at 2**S_W.
- Granted port drops s_valid mid-packet: the grant is held, m_valid follows s_valid, and no other port is served.
- Non-granted ports: their valid is ignored until the next IDLE cycle. They are never starved; maximum wait is N_PORTS−1 packets.
- m_src = grant in every state. Its value in IDLE is stale and carries no meaning.
- Reset value of every output and register:
  - state=IDLE, grant=0, prio=0.
  - m_valid=0, s_ready=0, m_src=0.
  - m_data and m_last mux port 0.
- Reset mid-packet: the packet is abandoned. Downstream sees no further beats of it, and arbitration restarts from port 0.
- There are no combinational paths from m_ready to m_valid, or from s_valid to s_ready.

## Timing
- Arbitration latency: s_valid rising in IDLE leads to m_valid the next cycle, at the earliest.
- Release is registered. The cycle after the releasing beat is always an IDLE bubble with m_valid=0.
- Throughput:
  - Packet lock: an L-beat packet occupies at least L+1 cycles.
  - No lock: every beat costs 2 cycles (50% peak).
- Backpressure: with m_ready=0 in LOCKED, the granted port stalls and the grant persists indefinitely.
- Against a full downstream FIFO: the arbiter holds, and no beat is lost or duplicated.

## Configuration
- AXIS_ARB_PKT_LOCK_EN defined:
  - The grant is held until an accepted beat with s_last=1.
  - Packets from different ports never interleave downstream.
- AXIS_ARB_PKT_LOCK_EN undefined:
  - Beat-level round-robin; release occurs after every accepted beat.
  - s_last is still forwarded on m_last unchanged, but it does not affect the grant.

## Test plan
- Reset, then hold all s_valid=0 for 10 cycles → m_valid=0, s_ready=0, m_src=0 throughout.
- Ports 0..3 all valid with 2-beat packets, m_ready=1, packet lock on → downstream order is port0 ×2, port1 ×2, port2 ×2, port3 ×2, port0 again. There is one bubble between packets, and m_src matches each beat's source.
- Only port 2 valid, 3 packets of 3 beats → 3 grants to port 2, each 4 cycles long. prio=3 after each release.
- Port 1 mid-packet with m_ready=0 for 5 cycles while port 0 is valid → s_ready=0b0000 throughout the stall. Port 1 finishes its packet before port 0 is granted.
- With prio=3, assert ports 0 and 3 simultaneously → port 3 wins, then port 0. prio wraps to 0 after port 3 is released.
- Assert rst mid-packet on port 2 (beat 2 of 4), then port 1 and port 2 request → state IDLE, and the first grant after reset goes to port 1 (prio=0 scan). No remaining beats from the old packet appear.
